rle_stream_coder: RTL and testbench
===================================

RLE_STREAM_CODER -- requirements
Module: rle_stream_coder

Interface
REQ-001 Parameter AW, default 15: address width of the read and write memories.
REQ-002 Parameter DW, default 1: sample width; DW=1 is the binary-image mode.
REQ-003 Parameter CW, default 4: run-count field width; MAXRUN = 2^CW-1.
REQ-004 Port clk  input  1: sole clock; all state changes on its rising edge.
REQ-005 Port rst  input  1: reset; synchronous and active-high.
REQ-006 Port start  input  1: frame start request; sampled in IDLE or DONE only.
REQ-007 Port len  input  AW+1: frame sample count, 0..2^AW; latched when start is accepted.
REQ-008 Port RData  input  DW: sample at mem[RAddr], valid in the same cycle (combinational read).
REQ-009 Port RAddr  output  AW: read address, registered.
REQ-010 Port WAddr  output  AW: write address, registered; in DONE it equals the number of words written.
REQ-011 Port WData  output  DW+CW: output word {value[DW-1:0], count[CW-1:0]}, with value in the MSBs; registered.
REQ-012 Port Wen  output  1: write strobe; one cycle per word; registered.
REQ-013 Port Finish  output  1: frame complete; registered and level-held.

Function
REQ-014 The FSM states SHALL be IDLE, LOAD, RUN, FLUSH and DONE.
REQ-015 IDLE or DONE with start=1 SHALL latch len, clear RAddr, WAddr and Finish, and go to LOAD if len!=0, else to DONE.
REQ-016 LOAD (RAddr=0) SHALL set cur=RData and cnt=1, increment RAddr, and go to RUN if len>1, else to FLUSH.
REQ-017 Each RUN cycle SHALL consume one sample at RAddr and then increment RAddr.
REQ-018 In RUN, if RData==cur and cnt<MAXRUN, then cnt SHALL increment with no write.
REQ-019 In RUN, if RData!=cur or cnt==MAXRUN, the block SHALL emit {cur,cnt}, then set cur=RData and cnt=1.
REQ-020 RUN SHALL go to FLUSH on the edge that consumes the sample at RAddr==len-1.
REQ-021 FLUSH SHALL emit {cur,cnt} and go to DONE.
REQ-022 Emit: at the edge, WData<={cur,cnt} and Wen<=1; Wen SHALL be high for exactly the following cycle, otherwise 0.
REQ-023 WAddr SHALL hold the destination address during the Wen cycle and increment on the edge ending that cycle; the first word goes to address 0.
REQ-024 Back-to-back emits SHALL produce consecutive Wen cycles with no word lost.
REQ-025 Finish SHALL rise on the edge after the final Wen cycle, or for len=0 on the edge after entering DONE, and hold until an accepted start or rst.
REQ-026 Latency for len>=1 SHALL be: LOAD in cycle 1 after start, final Wen in cycle len+2, Finish=1 from cycle len+3.
REQ-027 For len=0 there SHALL be no Wen pulse and WAddr SHALL remain 0.
REQ-028 start SHALL be ignored in LOAD, RUN and FLUSH.
REQ-029 RAddr SHALL never exceed len-1 during reads and SHALL hold its value in DONE.
REQ-030 cnt SHALL never be 0 and never exceed MAXRUN.
REQ-031 The count field of every word SHALL be in 1..MAXRUN.
REQ-032 The sum of the count fields of all words in a frame SHALL equal len.

Reset
REQ-033 While rst=1 at an edge, the next state SHALL be state=IDLE, RAddr=0, WAddr=0, WData=0, Wen=0, Finish=0, cur=0, cnt=0.
REQ-034 rst SHALL take priority over start and over every state, including mid-RUN and mid-Wen.
REQ-035 After rst deasserts, no write SHALL occur until a new start is accepted.

Verification
REQ-036 DW=1, CW=4, len=8, data 0,0,0,1,1,0,0,0 -> writes {0,3}@0, {1,2}@1, {0,3}@2; WData 0x03, 0x12, 0x03; Finish at cycle 11; WAddr=3.
REQ-037 len=20, all ones -> {1,15}@0 (0x1F), then {1,5}@1 (0x15); sum of counts = 20.
REQ-038 len=1, data 1 -> single write 0x11 @0 in cycle 3; Finish from cycle 4.
REQ-039 len=0 -> no Wen; Finish=1 from cycle 2; WAddr=0; start in DONE with len=2, data 1,0 -> writes 0x11 @0 and 0x01 @1.
REQ-040 rst asserted during RUN of a len=100 frame -> all outputs at reset values after the edge and no further Wen; a following start with len=3, data 0,0,0 -> single write 0x03 @0.
REQ-041 DW=8, CW=4, len=4, data A5,A5,3C,A5 -> writes 0xA52 @0, 0x3C1 @1, 0xA51 @2; Finish=1; WAddr=3.

Source files
------------

// File: rtl/rle_stream_coder.sv
// Run-length encoder: reads a frame of samples from memory and writes
// {value,count} words back, splitting runs longer than 2^CW-1.
module rle_stream_coder #(
    parameter int AW = 15,
    parameter int DW = 1,
    parameter int CW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AW:0]      len,
    input  logic [DW-1:0]    RData,
    output logic [AW-1:0]    RAddr,
    output logic [AW-1:0]    WAddr,
    output logic [DW+CW-1:0] WData,
    output logic             Wen,
    output logic             Finish
);

    localparam logic [CW-1:0] MAXRUN = '1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        FLUSH,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [AW:0]     len_q;
    logic [DW-1:0]   cur;
    logic [CW-1:0]   cnt;
    logic            emit;
    logic            last;

    assign last = ({1'b0, RAddr} == len_q - (AW+1)'(1));

    // Next-state selection and run-break detection
    always_comb begin
        state_nx = state;
        emit     = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) state_nx = (len != '0) ? LOAD : DONE;
            end
            LOAD: begin
                state_nx = (len_q > (AW+1)'(1)) ? RUN : FLUSH;
            end
            RUN: begin
                emit = (RData != cur) || (cnt == MAXRUN);
                if (last) state_nx = FLUSH;
            end
            FLUSH: begin
                emit     = 1'b1;
                state_nx = DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Datapath: read pointer, current run, output word and write pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q  <= '0;
            RAddr  <= '0;
            WAddr  <= '0;
            WData  <= '0;
            Wen    <= 1'b0;
            Finish <= 1'b0;
            cur    <= '0;
            cnt    <= '0;
        end else begin
            Wen   <= emit;
            WAddr <= WAddr + AW'(Wen);
            if (emit) WData <= {cur, cnt};
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        len_q  <= len;
                        RAddr  <= '0;
                        WAddr  <= '0;
                        Finish <= 1'b0;
                    end else if (state == DONE) begin
                        Finish <= 1'b1;
                    end
                end
                LOAD: begin
                    cur   <= RData;
                    cnt   <= CW'(1);
                    RAddr <= RAddr + AW'(1);
                end
                RUN: begin
                    RAddr <= RAddr + AW'(1);
                    if (emit) begin
                        cur <= RData;
                        cnt <= CW'(1);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rle_stream_coder.sv
// Bench for rle_stream_coder: binary-image instance and 8-bit instance
// driven frame by frame and compared against a run-splitting model.
module tb_rle_stream_coder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start1, start8;
    logic [15:0] len1;
    logic [8:0]  len8;

    logic        rdata1;
    logic [14:0] raddr1, waddr1;
    logic [4:0]  wdata1;
    logic        wen1, fin1;

    logic [7:0]  rdata8, raddr8, waddr8;
    logic [11:0] wdata8;
    logic        wen8, fin8;

    logic        mem1 [0:32767];
    logic [7:0]  mem8 [0:255];

    assign rdata1 = mem1[raddr1];
    assign rdata8 = mem8[raddr8];

    rle_stream_coder u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .len(len1),
        .RData(rdata1), .RAddr(raddr1), .WAddr(waddr1),
        .WData(wdata1), .Wen(wen1), .Finish(fin1)
    );

    rle_stream_coder #(.AW(8), .DW(8), .CW(4)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .len(len8),
        .RData(rdata8), .RAddr(raddr8), .WAddr(waddr8),
        .WData(wdata8), .Wen(wen8), .Finish(fin8)
    );

    int ntest = 0;
    int nfail = 0;
    int smp[$];
    int expw[$];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        ntest++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: find maximal runs, then cut each into chunks of at most 15
    function automatic void build_model();
        int i = 0;
        expw.delete();
        while (i < smp.size()) begin
            int v = smp[i];
            int l = 0;
            while (i < smp.size() && smp[i] == v) begin
                l++;
                i++;
            end
            while (l > 0) begin
                int c = (l > 15) ? 15 : l;
                expw.push_back(v * 16 + c);
                l -= c;
            end
        end
    endfunction

    task automatic load_mem(input int which);
        for (int i = 0; i < smp.size(); i++) begin
            int v = smp[i];
            if (which == 0) mem1[i] = v[0];
            else            mem8[i] = v[7:0];
        end
    endtask

    task automatic run_frame(input int which, input bit poke,
                             input string nm);
        int n = smp.size();
        int gotw[$];
        int gota[$];
        int lastw = 0;
        int finc = 0;
        int sum = 0;
        int clash = 0;
        logic w, f;
        logic [63:0] d, a;
        build_model();
        load_mem(which);
        @(negedge clk);
        if (which == 0) begin start1 = 1'b1; len1 = 16'(n); end
        else            begin start8 = 1'b1; len8 = 9'(n); end
        @(negedge clk);
        start1 = 1'b0;
        start8 = 1'b0;
        for (int c = 1; c <= n + 8; c++) begin
            if (c > 1) @(negedge clk);
            w = (which == 0) ? wen1 : wen8;
            f = (which == 0) ? fin1 : fin8;
            d = (which == 0) ? 64'(wdata1) : 64'(wdata8);
            a = (which == 0) ? 64'(waddr1) : 64'(waddr8);
            if (w) begin
                gotw.push_back(int'(d));
                gota.push_back(int'(a));
                lastw = c;
                if (f) clash++;
            end
            if (f && finc == 0) finc = c;
            if (poke && c == 2) begin
                start1 = (which == 0);
                start8 = (which != 0);
                len1 = 16'd1;
                len8 = 9'd1;
            end
            if (c == 3) begin
                start1 = 1'b0;
                start8 = 1'b0;
            end
        end
        chk({nm, " nwords"}, 64'(gotw.size()), 64'(expw.size()));
        for (int i = 0; i < gotw.size() && i < expw.size(); i++) begin
            chk($sformatf("%s word%0d", nm, i), 64'(gotw[i]), 64'(expw[i]));
            chk($sformatf("%s addr%0d", nm, i), 64'(gota[i]), 64'(i));
            sum += gotw[i] % 16;
        end
        chk({nm, " countsum"}, 64'(sum), 64'(n));
        chk({nm, " lastwen"}, 64'(lastw), 64'((n == 0) ? 0 : n + 2));
        chk({nm, " fincyc"}, 64'(finc), 64'((n == 0) ? 2 : n + 3));
        chk({nm, " wen_fin"}, 64'(clash), 64'(0));
        a = (which == 0) ? 64'(waddr1) : 64'(waddr8);
        chk({nm, " waddr_end"}, a, 64'(expw.size()));
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, " raddr1"}, 64'(raddr1), 64'(0));
        chk({nm, " waddr1"}, 64'(waddr1), 64'(0));
        chk({nm, " wdata1"}, 64'(wdata1), 64'(0));
        chk({nm, " wen1"},   64'(wen1),   64'(0));
        chk({nm, " fin1"},   64'(fin1),   64'(0));
        chk({nm, " raddr8"}, 64'(raddr8), 64'(0));
        chk({nm, " wdata8"}, 64'(wdata8), 64'(0));
        chk({nm, " fin8"},   64'(fin8),   64'(0));
    endtask

    task automatic rand_bits(input int n);
        int v = int'($urandom_range(1));
        smp.delete();
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(3) == 0) v = 1 - v;
            smp.push_back(v);
        end
    endtask

    initial begin
        int wc;
        rst = 1'b1;
        start1 = 1'b0;
        start8 = 1'b0;
        len1 = '0;
        len8 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("por");
        rst = 1'b0;

        smp = '{0, 0, 0, 1, 1, 0, 0, 0};
        run_frame(0, 1'b0, "basic8");
        smp.delete();
        for (int i = 0; i < 20; i++) smp.push_back(1);
        run_frame(0, 1'b0, "ones20");
        smp.delete();
        for (int i = 0; i < 15; i++) smp.push_back(1);
        run_frame(0, 1'b0, "ones15");
        smp = '{1};
        run_frame(0, 1'b0, "len1");
        smp.delete();
        run_frame(0, 1'b0, "len0");
        smp = '{1, 0};
        run_frame(0, 1'b0, "len2");

        rand_bits(100);
        load_mem(0);
        @(negedge clk);
        start1 = 1'b1;
        len1 = 16'd100;
        @(negedge clk);
        start1 = 1'b0;
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_vals("midrun");
        @(negedge clk);
        rst = 1'b0;
        wc = 0;
        repeat (12) begin
            @(negedge clk);
            if (wen1) wc++;
        end
        chk("post_rst_wen", 64'(wc), 64'(0));
        smp = '{0, 0, 0};
        run_frame(0, 1'b0, "after_rst");

        smp = '{'hA5, 'hA5, 'h3C, 'hA5};
        run_frame(1, 1'b0, "dw8");

        for (int k = 0; k < 6; k++) begin
            rand_bits(int'($urandom_range(40, 1)));
            run_frame(0, 1'b1, $sformatf("rnd1_%0d", k));
        end
        for (int k = 0; k < 4; k++) begin
            int n = int'($urandom_range(40, 1));
            int v = int'($urandom_range(255));
            smp.delete();
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(2) == 0) v = int'($urandom_range(3)) * 85;
                smp.push_back(v);
            end
            run_frame(1, 1'b1, $sformatf("rnd8_%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

endmodule
